// File: rtl/util_mw_adc_pkg.sv
// Shared types for the ADC capture path: capture FSM encoding and channel limit.
// No logic; imported by the capture controller.
package util_mw_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int MAX_CHAN = 8;

endpackage

// File: rtl/util_mw_edge_det.sv
// Rising-edge detector: one history flop, rise = din & ~previous din.
// Latency: combinational on the current input against last cycle's sample; no backpressure.
// Backpressure: not applicable, free-running every cycle.
module util_mw_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/util_mw_adc_capture_ctl.sv
// Capture sequencer: gates a bounded (or continuous) burst of ADC samples into the DMAC write port.
// Latency: one cycle from data_in/data_in_valid to dmac_data/dmac_valid.
// Backpressure: none; the DMAC cannot stall us, its overflow flag is only latched into sts_ovf.
// Build option: UTIL_MW_ADC_CAPTURE_TRIG_EN adds the ARMED state and trig_in rising-edge start.
module util_mw_adc_capture_ctl
    import util_mw_adc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CHAN   = 4,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                           adc_clk,
    input  logic                           adc_rst,
    input  logic                           ctl_arm,
    input  logic                           ctl_abort,
    input  logic [CNT_WIDTH-1:0]           ctl_len,
    input  logic                           trig_in,
    input  logic [DATA_WIDTH*NUM_CHAN-1:0] data_in,
    input  logic                           data_in_valid,
    output logic [DATA_WIDTH*NUM_CHAN-1:0] dmac_data,
    output logic                           dmac_valid,
    output logic                           dmac_sync,
    input  logic                           dmac_ovf,
    output logic                           sts_busy,
    output logic                           sts_done,
    output logic                           sts_ovf,
    output logic [CNT_WIDTH-1:0]           sts_count
);

    cap_state_t           state;
    logic [CNT_WIDTH-1:0] len_q;
    logic                 first_q;
    logic                 trig_rise;
    logic                 fwd;
    logic                 last;

`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
    localparam cap_state_t ARM_TARGET = ST_ARMED;

    util_mw_edge_det u_trig_det (
        .clk  (adc_clk),
        .rst  (adc_rst),
        .din  (trig_in),
        .rise (trig_rise)
    );
`else
    localparam cap_state_t ARM_TARGET = ST_CAPTURE;

    logic unused_trig;
    assign unused_trig = trig_in;
    assign trig_rise   = 1'b0;
`endif

    assign fwd  = (state == ST_CAPTURE) && data_in_valid;
    // A zero length means continuous capture, so it never matches here.
    assign last = fwd && (len_q != '0) && (sts_count == len_q - 1'b1);

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            first_q    <= 1'b0;
            dmac_data  <= '0;
            dmac_valid <= 1'b0;
            dmac_sync  <= 1'b0;
            sts_busy   <= 1'b0;
            sts_done   <= 1'b0;
            sts_ovf    <= 1'b0;
            sts_count  <= '0;
        end else begin
            dmac_valid <= fwd;
            dmac_sync  <= fwd && first_q;
            sts_done   <= 1'b0;
            if (fwd) begin
                dmac_data <= data_in;
                first_q   <= 1'b0;
                if (sts_count != '1) begin
                    sts_count <= sts_count + 1'b1;
                end
            end
            if (dmac_ovf && sts_busy) begin
                sts_ovf <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (ctl_arm && !ctl_abort) begin
                        state     <= ARM_TARGET;
                        len_q     <= ctl_len;
                        first_q   <= 1'b1;
                        sts_count <= '0;
                        sts_ovf   <= 1'b0;
                        sts_busy  <= 1'b1;
                    end
                end
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
                ST_ARMED: begin
                    if (ctl_abort) begin
                        state    <= ST_IDLE;
                        sts_busy <= 1'b0;
                    end else if (trig_rise) begin
                        state <= ST_CAPTURE;
                    end
                end
`endif
                ST_CAPTURE: begin
                    if (ctl_abort) begin
                        state    <= ST_IDLE;
                        sts_busy <= 1'b0;
                    end else if (last) begin
                        state    <= ST_DONE;
                        sts_busy <= 1'b0;
                        sts_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    sts_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_util_mw_adc_capture_ctl.sv
// Directed bench for the ADC capture sequencer with a forwarded-sample scoreboard.
module tb_util_mw_adc_capture_ctl;

    localparam int DW = 64;
    localparam int CW = 24;

    logic          adc_clk = 1'b0;
    logic          adc_rst = 1'b1;
    logic          ctl_arm = 1'b0;
    logic          ctl_abort = 1'b0;
    logic [CW-1:0] ctl_len = '0;
    logic          trig_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [DW-1:0] dmac_data;
    logic          dmac_valid;
    logic          dmac_sync;
    logic          dmac_ovf = 1'b0;
    logic          sts_busy;
    logic          sts_done;
    logic          sts_ovf;
    logic [CW-1:0] sts_count;

    util_mw_adc_capture_ctl #(
        .DATA_WIDTH (16),
        .NUM_CHAN   (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .adc_clk       (adc_clk),
        .adc_rst       (adc_rst),
        .ctl_arm       (ctl_arm),
        .ctl_abort     (ctl_abort),
        .ctl_len       (ctl_len),
        .trig_in       (trig_in),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .dmac_data     (dmac_data),
        .dmac_valid    (dmac_valid),
        .dmac_sync     (dmac_sync),
        .dmac_ovf      (dmac_ovf),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_ovf       (sts_ovf),
        .sts_count     (sts_count)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sync;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            fwd_cnt = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    logic [DW-1:0] last_dat = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    // Drive one valid sample; when fwd is set it is expected at the DMAC.
    task automatic sample(input logic fwd, input logic sync);
        logic [DW-1:0] d;
        d = {$urandom(), $urandom()};
        data_in       = d;
        data_in_valid = 1'b1;
        if (fwd) begin
            sb_q.push_back('{dat: d, sync: sync});
            last_dat = d;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  dmac_data, 64'd0);
        check({tag, "_valid"}, dmac_valid, 1'b0);
        check({tag, "_sync"},  dmac_sync, 1'b0);
        check({tag, "_busy"},  sts_busy, 1'b0);
        check({tag, "_done"},  sts_done, 1'b0);
        check({tag, "_ovf"},   sts_ovf, 1'b0);
        check({tag, "_count"}, sts_count, 64'd0);
    endtask

    always @(negedge adc_clk) begin
        if (sts_done === 1'b1) done_cnt++;
        if (dmac_valid === 1'b1) begin
            exp_t e;
            fwd_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", dmac_data, e.dat);
                check("sb_sync", dmac_sync, e.sync);
            end
        end
    end

    initial begin
        int base;

        // Reset state
        step();
        step();
        check_reset_outputs("reset");
        adc_rst = 1'b0;
        step();

        // Length 4, no trigger, 6 back-to-back valids
        ctl_len = 24'd4;
        ctl_arm = 1'b1;
        base = fwd_cnt;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        check("len4_busy_after_arm", sts_busy, 1'b1);
        check("len4_count_after_arm", sts_count, 64'd0);
        for (int i = 0; i < 6; i++) begin
            sample(i < 4, i == 0);
            step();
            if (i == 3) begin
                exp_done++;
                check("len4_done_pulse", sts_done, 1'b1);
                check("len4_busy_at_done", sts_busy, 1'b0);
                check("len4_count", sts_count, 64'd4);
            end
            if (i == 4) check("len4_done_one_cycle", sts_done, 1'b0);
        end
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        step();
        check("len4_fwd_total", fwd_cnt - base, 4);
        check("len4_data_hold", dmac_data, last_dat);

        // Length 0: continuous, 100 samples then abort
        ctl_len = 24'd0;
        ctl_arm = 1'b1;
        base = fwd_cnt;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        for (int i = 0; i < 100; i++) begin
            sample(1'b1, i == 0);
            step();
        end
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        check("cont_busy_before_abort", sts_busy, 1'b1);
        ctl_abort = 1'b1;
        step();
        ctl_abort = 1'b0;
        check("cont_busy_after_abort", sts_busy, 1'b0);
        check("cont_count", sts_count, 64'd100);
        step();
        check("cont_fwd_total", fwd_cnt - base, 100);

`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        // Trigger: valids in ARMED and on the edge cycle are dropped
        ctl_len = 24'd3;
        ctl_arm = 1'b1;
        base = fwd_cnt;
        step();
        ctl_arm = 1'b0;
        check("trig_busy_armed", sts_busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            sample(1'b0, 1'b0);
            step();
        end
        trig_in = 1'b1;
        sample(1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            sample(1'b1, i == 0);
            step();
        end
        exp_done++;
        check("trig_done", sts_done, 1'b1);
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        step();
        check("trig_fwd_total", fwd_cnt - base, 3);
`endif

        // Arm and abort together: ignored, previous count retained
        ctl_len = 24'd2;
        ctl_arm = 1'b1;
        ctl_abort = 1'b1;
        step();
        ctl_arm = 1'b0;
        ctl_abort = 1'b0;
        check("armabort_busy", sts_busy, 1'b0);
        step();
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        check("armabort_count_kept", sts_count, 64'd3);
`else
        check("armabort_count_kept", sts_count, 64'd100);
`endif

        // Re-arm during CAPTURE is ignored; abort cycle sample still forwarded
        ctl_len = 24'd0;
        ctl_arm = 1'b1;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        sample(1'b1, 1'b1);
        step();
        sample(1'b1, 1'b0);
        step();
        sample(1'b1, 1'b0);
        ctl_len = 24'd1;
        ctl_arm = 1'b1;
        step();
        ctl_arm = 1'b0;
        check("rearm_count_kept", sts_count, 64'd3);
        sample(1'b1, 1'b0);
        ctl_abort = 1'b1;
        step();
        ctl_abort = 1'b0;
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        check("abort_valid_fwd", dmac_valid, 1'b1);
        check("abort_count", sts_count, 64'd4);
        check("abort_busy", sts_busy, 1'b0);
        step();
        check("abort_no_done", sts_done, 1'b0);

        // Overflow is sticky past done and cleared by the next arm
        ctl_len = 24'd5;
        ctl_arm = 1'b1;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, i == 0);
            dmac_ovf = (i == 2);
            step();
            if (i == 2) check("ovf_set", sts_ovf, 1'b1);
        end
        exp_done++;
        dmac_ovf = 1'b0;
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        check("ovf_done", sts_done, 1'b1);
        step();
        step();
        check("ovf_sticky_after_done", sts_ovf, 1'b1);
        ctl_len = 24'd2;
        ctl_arm = 1'b1;
        step();
        ctl_arm = 1'b0;
        check("ovf_cleared_by_arm", sts_ovf, 1'b0);
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        for (int i = 0; i < 2; i++) begin
            sample(1'b1, i == 0);
            step();
        end
        exp_done++;
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        step();

        // Reset after 2 of 8 samples, then a full 8-sample burst
        ctl_len = 24'd8;
        ctl_arm = 1'b1;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        for (int i = 0; i < 2; i++) begin
            sample(1'b1, i == 0);
            step();
        end
        sample(1'b0, 1'b0);
        trig_in = 1'b0;
        adc_rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        adc_rst = 1'b0;
        data_in_valid = 1'b0;
        step();
        check("midrst_no_done", sts_done, 1'b0);
        check("midrst_sb_drained", sb_q.size(), 0);
        ctl_len = 24'd8;
        ctl_arm = 1'b1;
        base = fwd_cnt;
        step();
        ctl_arm = 1'b0;
`ifdef UTIL_MW_ADC_CAPTURE_TRIG_EN
        trig_in = 1'b1;
        step();
`endif
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, i == 0);
            step();
        end
        exp_done++;
        data_in_valid = 1'b0;
        trig_in = 1'b0;
        check("rst_burst_done", sts_done, 1'b1);
        check("rst_burst_count", sts_count, 64'd8);
        step();
        step();
        check("rst_burst_fwd_total", fwd_cnt - base, 8);
        check("done_total", done_cnt, exp_done);
        check("sb_empty_at_end", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/util_mw_adc_capture_ctl.md
# util_mw_adc_capture_ctl

Capture sequencer between the ADC bridge return path and the DMA write port. It takes the packed user-IP output and its valid, then gates a bounded burst of exactly `ctl_len` samples (or continuous capture) into the DMAC. Capture start can optionally be held off until an external trigger. It reports busy, done, overflow and progress to the register interface.

## Interface
- `DATA_WIDTH`, 16: bits per channel.
- `NUM_CHAN`, 4: channels packed in `data_in`, 1..8.
- `CNT_WIDTH`, 24: sample counter and length width.
- `adc_clk`  in  1  sole clock; all logic is on its rising edge.
- `adc_rst`  in  1  synchronous, active-high reset.
- `ctl_arm`  in  1  single-cycle start request.
- `ctl_abort`  in  1  single-cycle stop request.
- `ctl_len`  in  CNT_WIDTH  samples per burst; 0 = continuous; sampled on accepted arm.
- `trig_in`  in  1  external trigger level (used only with the macro).
- `data_in`  in  DATA_WIDTH*NUM_CHAN  packed channels, channel 0 in the LSBs.
- `data_in_valid`  in  1  sample strobe.
- `dmac_data`  out  DATA_WIDTH*NUM_CHAN  registered sample.
- `dmac_valid`  out  1  write strobe to the DMAC.
- `dmac_sync`  out  1  high with the first sample of a burst.
- `dmac_ovf`  in  1  DMAC overflow flag.
- `sts_busy`  out  1  high in ARMED or CAPTURE.
- `sts_done`  out  1  one-cycle pulse when a burst completes normally.
- `sts_ovf`  out  1  sticky overflow flag.
- `sts_count`  out  CNT_WIDTH  samples forwarded in the current or last burst.

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - An arm with no abort latches `ctl_len`, clears `sts_count` and `sts_ovf`, and goes to ARMED if the trigger is compiled in, else to CAPTURE.
  - Arm while not IDLE is ignored.
- ARMED: on a `trig_in` rising edge (`trig_in`=1 and previous sample 0), go to CAPTURE on the next cycle.
- CAPTURE:
  - Each `data_in_valid` forwards `data_in` and increments `sts_count`.
  - If the latched length is nonzero and this valid is sample number len (count==len-1), go to DONE.
  - If the latched length is 0, never complete.
  - `sts_count` saturates at all-ones; forwarding continues.
- DONE: assert `sts_done` for exactly one cycle, then go to IDLE.
- `ctl_abort` in any non-IDLE state goes to IDLE next cycle with no `sts_done`.
  - A sample valid in the abort cycle is still forwarded.
  - Abort and arm in the same cycle: abort wins, no capture starts.
- `sts_ovf` is set by `dmac_ovf`=1 while `sts_busy`. It is sticky until the next accepted arm or reset.
- `dmac_data` holds its last value when `dmac_valid`=0.

## Timing
- Reset values: state IDLE, `dmac_data`=0, `dmac_valid`=0, `dmac_sync`=0, `sts_busy`=0, `sts_done`=0, `sts_ovf`=0, `sts_count`=0, trigger history 0.
- Latency: `data_in`/`data_in_valid` in cycle t appear as `dmac_data`/`dmac_valid` in cycle t+1.
- `dmac_sync` is asserted with the first forwarded sample after entering CAPTURE only.
- Arm at t:
  - no trigger: CAPTURE from t+1; a valid at t+1 is the first sample.
  - with trigger: ARMED from t+1; edge at t2 gives CAPTURE from t2+1, and the valid at t2 is not captured.
- Last sample at t: `dmac_valid` at t+1, DONE at t+1 (`sts_done`=1), IDLE at t+2, `sts_busy`=0 at t+1. A re-arm is accepted from t+2.
- Reset asserted mid-burst: all outputs return to reset values on the next edge, and no `sts_done` is produced.

## Configuration
- `UTIL_MW_ADC_CAPTURE_TRIG_EN`
  - Defined: ARMED state and rising-edge detector on `trig_in` are built in.
  - Undefined: ARMED is removed, arm goes straight to CAPTURE, and `trig_in` is ignored.

## Structure
- Shared package `util_mw_adc_pkg`: FSM state enum (IDLE, ARMED, CAPTURE, DONE) and the maximum channel count constant 8.
- One sub-module, `util_mw_edge_det`: registered rising-edge detector for `trig_in`, instantiated only under the macro.
- Counter, FSM and output register stay in the top level.

## Test plan
- Length 4, no trigger: arm, then 6 continuous valids → exactly 4 `dmac_valid`, `dmac_sync` on the first, `sts_done` one cycle after the 4th, `sts_count`=4.
- Length 0: arm, 100 valids, then abort → 100 forwarded, no `sts_done`, `sts_busy` falls the cycle after abort.
- With the macro, length 3: arm, valids during ARMED and on the trigger-edge cycle are dropped; the next 3 valids are forwarded.
- Arm and abort in the same cycle → state stays IDLE, `sts_busy`=0; arm during CAPTURE does not reset `sts_count`.
- `dmac_ovf` pulse mid-burst → `sts_ovf`=1 persists after done and clears on the next arm.
- `adc_rst` asserted after 2 of 8 samples → all outputs 0 next cycle; a fresh arm then runs a full 8-sample burst.
